uart_fifo_ctrl: RTL and testbench
=================================

Name: uart_fifo_ctrl

Overview:
Host-side controller for the uart byte interface; it drives `transmit`/`tx_byte` and consumes `received`/`rx_byte`/`recv_error`.
It buffers outgoing bytes in a TX FIFO and paces them into the uart one at a time using `is_transmitting`.
It captures incoming bytes into an RX FIFO with sticky overrun and error flags.
It sits between the CPU peripheral bus decode and the uart core.

Parameters:
TX_AW, 4, log2 of TX FIFO depth (16 entries)
RX_AW, 4, log2 of RX FIFO depth (16 entries)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  host push of wr_data into TX FIFO
wr_data  in  8  byte to transmit
tx_full  out  1  TX FIFO full
tx_level  out  TX_AW+1  TX FIFO occupancy
rd_en  in  1  host pop of RX FIFO head
rd_data  out  8  RX FIFO head (show-ahead; valid when !rx_empty)
rx_empty  out  1  RX FIFO empty
rx_level  out  RX_AW+1  RX FIFO occupancy
rx_overrun  out  1  sticky: byte dropped because RX FIFO was full
rx_error  out  1  sticky: uart reported a framing error
clr_flags  in  1  clears rx_overrun and rx_error
uart_transmit  out  1  one-cycle transmit request to uart
uart_tx_byte  out  8  byte presented with uart_transmit
uart_is_transmitting  in  1  uart busy
uart_received  in  1  one-cycle byte-valid pulse from uart
uart_rx_byte  in  8  received byte, valid with uart_received
uart_recv_error  in  1  uart framing-error indication

Behaviour:
- Reset (async, rst=1) forces:
  - both FIFO pointers and levels to 0, so tx_full=0, rx_empty=1;
  - rx_overrun=0, rx_error=0, uart_transmit=0, uart_tx_byte=0;
  - the TX sequencer to TX_IDLE.
- A byte in flight inside the uart is not tracked across reset; the controller does not wait for it.
- TX FIFO:
  - wr_en with !tx_full pushes wr_data; wr_en while full is ignored (no flag).
  - Simultaneous push and pop when full: only the pop occurs.
  - Pointers are TX_AW bits and wrap naturally. The level counter is TX_AW+1 bits; full when level == 2^TX_AW.
- TX sequencer states:
  - TX_IDLE: if level>0, pop head into uart_tx_byte, assert uart_transmit for exactly one cycle, go TX_WAIT_BUSY.
  - TX_WAIT_BUSY: wait for uart_is_transmitting=1, then go TX_WAIT_DONE. uart_transmit stays 0.
  - TX_WAIT_DONE: wait for uart_is_transmitting=0, then go TX_IDLE.
  - Next byte issue is at the earliest the cycle after re-entering TX_IDLE, so uart_transmit is never asserted while the uart is busy or in its restart delay.
  - uart_tx_byte holds its value until the next issue.
- RX FIFO:
  - uart_received pushes uart_rx_byte.
  - If full and rd_en is not asserted the same cycle, the byte is dropped and rx_overrun sets.
  - If full and rd_en is asserted the same cycle, the push and pop both happen; level is unchanged, no overrun.
  - rd_en while empty is ignored.
  - rd_data is combinational from the head entry and updates the cycle after a pop.
- uart_recv_error=1 in any cycle sets rx_error. Nothing is pushed on error.
- Sticky flags:
  - clr_flags clears them.
  - A set event in the same cycle as clr_flags wins (flag ends 1).
- Latencies:
  - wr_en into an empty FIFO with the sequencer idle: uart_transmit asserts 2 cycles later (push cycle, then the issue cycle's register).
  - uart_received: rx_empty deasserts the next cycle.

Decomposition:
- Shared package uart_pkg holds:
  - the TX sequencer state constants TX_IDLE=2'd0, TX_WAIT_BUSY=2'd1, TX_WAIT_DONE=2'd2;
  - the default FIFO widths.
- One natural sub-module, uart_sync_fifo:
  - parameterised 8-bit data, AW;
  - push/pop/full/empty/level, show-ahead read, async active-high reset;
  - instantiated twice (TX and RX).
- The sequencer and flag logic live in uart_fifo_ctrl.

Test Plan:
- Write 0x41, 0x42, 0x43, with a uart model that busies for 20 cycles per byte.
  - Expect exactly three uart_transmit pulses, bytes 0x41, 0x42, 0x43 in order.
  - Each pulse occurs only after is_transmitting has fallen.
- Write 17 bytes with the uart held busy.
  - Expect tx_full=1 after the 16th write and tx_level=16; the 17th write is ignored.
  - After release, exactly 16 bytes are sent.
- Pulse uart_received 16 times (0x00..0x0F), then once more with 0x10.
  - Expect rx_level=16 and rx_overrun=1.
  - Draining yields 0x00..0x0F, then rx_empty=1.
- With the RX FIFO full, assert uart_received(0x55) and rd_en in the same cycle.
  - Expect rx_overrun=0 and rx_level=16; 0x55 is read last.
- Pulse uart_recv_error with clr_flags in the same cycle.
  - Expect rx_error=1 and rx_level unchanged.
  - A later clr_flags alone clears rx_error to 0.
- Assert rst mid-TX_WAIT_DONE with 5 bytes queued.
  - Immediately (asynchronously) expect tx_level=0, uart_transmit=0, rx_empty=1.
  - After release, no transmit is issued.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared TX sequencer states and default FIFO widths for the uart host controller
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_e;

    localparam int DEF_TX_AW = 4;
    localparam int DEF_RX_AW = 4;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous show-ahead byte FIFO with occupancy count
module uart_sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    always_comb begin
        do_pop   = pop && (level_q != '0);
        do_push  = push && ((level_q != FULL_LEVEL) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = (level_q == FULL_LEVEL);
    assign empty     = (level_q == '0);
    assign level     = level_q;

endmodule

// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - host-side uart controller: buffered, paced TX and RX capture with sticky flags
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int TX_AW = DEF_TX_AW,
    parameter int RX_AW = DEF_RX_AW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [7:0]   wr_data,
    output logic         tx_full,
    output logic [TX_AW:0] tx_level,
    input  logic         rd_en,
    output logic [7:0]   rd_data,
    output logic         rx_empty,
    output logic [RX_AW:0] rx_level,
    output logic         rx_overrun,
    output logic         rx_error,
    input  logic         clr_flags,
    output logic         uart_transmit,
    output logic [7:0]   uart_tx_byte,
    input  logic         uart_is_transmitting,
    input  logic         uart_received,
    input  logic [7:0]   uart_rx_byte,
    input  logic         uart_recv_error
);

    tx_state_e  state_q, state_d;
    logic       transmit_q, transmit_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       overrun_q, overrun_d;
    logic       error_q, error_d;

    logic       tx_push, tx_pop, tx_empty;
    logic [7:0] tx_head;
    logic       rx_push, rx_full;

    assign tx_push = wr_en && !tx_full;
    assign rx_push = uart_received && !uart_recv_error;

    uart_sync_fifo #(.DW(8), .AW(TX_AW)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (wr_data),
        .pop       (tx_pop),
        .head_data (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    uart_sync_fifo #(.DW(8), .AW(RX_AW)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (uart_rx_byte),
        .pop       (rd_en),
        .head_data (rd_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    // Issue is also held off while the uart still reports busy, so a request never lands mid-byte.
    always_comb begin
        state_d    = state_q;
        transmit_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        tx_pop     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!tx_empty && !uart_is_transmitting) begin
                    tx_pop     = 1'b1;
                    tx_byte_d  = tx_head;
                    transmit_d = 1'b1;
                    state_d    = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (uart_is_transmitting) begin
                    state_d = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Set beats clear when both occur in the same cycle.
    always_comb begin
        overrun_d = (overrun_q && !clr_flags) || (rx_push && rx_full && !rd_en);
        error_d   = (error_q && !clr_flags) || uart_recv_error;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            overrun_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
            overrun_q  <= overrun_d;
            error_q    <= error_d;
        end
    end

    assign uart_transmit = transmit_q;
    assign uart_tx_byte  = tx_byte_q;
    assign rx_overrun    = overrun_q;
    assign rx_error      = error_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - self-checking bench for uart_fifo_ctrl with queue model and busy-uart model
module tb_uart_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_full;
    logic [4:0] tx_level;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic [4:0] rx_level;
    logic       rx_overrun;
    logic       rx_error;
    logic       clr_flags = 1'b0;
    logic       uart_transmit;
    logic [7:0] uart_tx_byte;
    logic       uart_is_transmitting;
    logic       uart_received = 1'b0;
    logic [7:0] uart_rx_byte = 8'h00;
    logic       uart_recv_error = 1'b0;

    uart_fifo_ctrl #(.TX_AW(4), .RX_AW(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .wr_en                (wr_en),
        .wr_data              (wr_data),
        .tx_full              (tx_full),
        .tx_level             (tx_level),
        .rd_en                (rd_en),
        .rd_data              (rd_data),
        .rx_empty             (rx_empty),
        .rx_level             (rx_level),
        .rx_overrun           (rx_overrun),
        .rx_error             (rx_error),
        .clr_flags            (clr_flags),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .uart_received        (uart_received),
        .uart_rx_byte         (uart_rx_byte),
        .uart_recv_error      (uart_recv_error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] sent[$];
    logic       m_ovr = 1'b0;
    logic       m_err = 1'b0;
    logic       saw_busy = 1'b1;
    int         busy_cnt = 0;
    logic       hold_busy = 1'b0;

    assign uart_is_transmitting = hold_busy || (busy_cnt > 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after a falling edge, so at the falling edge they still hold
    // what the DUT sampled on the preceding rising edge.
    always @(negedge clk) begin
        int pre_tx;
        int pre_rx;
        logic ovr_set;
        logic [7:0] exp_b;
        ovr_set = 1'b0;
        if (rst) begin
            txq.delete();
            rxq.delete();
            m_ovr    = 1'b0;
            m_err    = 1'b0;
            saw_busy = 1'b1;
            chk("rst_transmit", uart_transmit, 0);
        end else begin
            if (uart_is_transmitting) saw_busy = 1'b1;
            pre_tx = txq.size();
            if (uart_transmit) begin
                chk("issue_while_idle", uart_is_transmitting, 0);
                chk("issue_after_busy", saw_busy, 1);
                chk("issue_nonempty", pre_tx > 0, 1);
                if (pre_tx > 0) begin
                    exp_b = txq.pop_front();
                    chk("tx_byte", uart_tx_byte, exp_b);
                end
                sent.push_back(uart_tx_byte);
                saw_busy = 1'b0;
            end
            if (wr_en && pre_tx < 16) txq.push_back(wr_data);
            pre_rx = rxq.size();
            if (rd_en && pre_rx > 0) void'(rxq.pop_front());
            if (uart_received && !uart_recv_error) begin
                if (pre_rx < 16 || rd_en) rxq.push_back(uart_rx_byte);
                else ovr_set = 1'b1;
            end
            m_ovr = (m_ovr && !clr_flags) || ovr_set;
            m_err = (m_err && !clr_flags) || uart_recv_error;
        end
        chk("tx_level", tx_level, txq.size());
        chk("tx_full", tx_full, txq.size() == 16);
        chk("rx_level", rx_level, rxq.size());
        chk("rx_empty", rx_empty, rxq.size() == 0);
        if (rxq.size() > 0) chk("rd_data", rd_data, rxq[0]);
        chk("rx_overrun", rx_overrun, m_ovr);
        chk("rx_error", rx_error, m_err);
        if (uart_transmit && !rst) busy_cnt = 20;
        else if (busy_cnt > 0) busy_cnt--;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic recv(input logic [7:0] b);
        uart_received = 1'b1; uart_rx_byte = b;
        tick();
        uart_received = 1'b0;
    endtask

    task automatic read_chk(input logic [7:0] exp);
        chk("drain_data", rd_data, exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_sent(input int n, input int budget);
        int k;
        k = 0;
        while (sent.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_sent_timeout", sent.size() >= n, 1);
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_tx_level", tx_level, 0);
        chk("reset_tx_full", tx_full, 0);
        chk("reset_rx_empty", rx_empty, 1);
        chk("reset_tx_byte", uart_tx_byte, 8'h00);
        rst = 1'b0;
        tick();

        // Three bytes through a uart that stays busy 20 cycles per byte.
        write(8'h41);
        chk("latency_cycle1", uart_transmit, 0);
        write(8'h42);
        chk("latency_cycle2", uart_transmit, 1);
        chk("latency_byte", uart_tx_byte, 8'h41);
        write(8'h43);
        wait_sent(3, 200);
        repeat (30) tick();
        chk("t1_count", sent.size(), 3);
        for (int i = 0; i < 3; i++) chk("t1_order", sent[i], 8'h41 + i);
        chk("t1_tx_empty", tx_level, 0);

        // Fill the TX FIFO while the uart is held busy.
        sent.delete();
        hold_busy = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) write(8'h60 + 8'(i));
        chk("t2_full", tx_full, 1);
        chk("t2_level16", tx_level, 16);
        write(8'h70);
        chk("t2_ignored", tx_level, 16);
        chk("t2_none_sent", sent.size(), 0);
        hold_busy = 1'b0;
        wait_sent(16, 700);
        repeat (30) tick();
        chk("t2_count", sent.size(), 16);
        for (int i = 0; i < 16; i++) chk("t2_order", sent[i], 8'h60 + i);

        // RX overrun and drain.
        for (int i = 0; i < 16; i++) recv(8'(i));
        chk("t3_level16", rx_level, 16);
        chk("t3_no_ovr", rx_overrun, 0);
        recv(8'h10);
        chk("t3_ovr", rx_overrun, 1);
        chk("t3_level_hold", rx_level, 16);
        for (int i = 0; i < 16; i++) read_chk(8'(i));
        chk("t3_empty", rx_empty, 1);
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk("t3_ovr_clr", rx_overrun, 0);

        // Full RX with a simultaneous push and pop.
        for (int i = 0; i < 16; i++) recv(8'h20 + 8'(i));
        uart_received = 1'b1; uart_rx_byte = 8'h55; rd_en = 1'b1;
        tick();
        uart_received = 1'b0; rd_en = 1'b0;
        chk("t4_no_ovr", rx_overrun, 0);
        chk("t4_level16", rx_level, 16);
        for (int i = 0; i < 16; i++) read_chk((i < 15) ? 8'h21 + 8'(i) : 8'h55);
        chk("t4_empty", rx_empty, 1);

        // Framing error coinciding with clear; errored byte not stored.
        recv(8'hA1);
        recv(8'hA2);
        uart_received = 1'b1; uart_rx_byte = 8'h99; uart_recv_error = 1'b1; clr_flags = 1'b1;
        tick();
        uart_received = 1'b0; uart_recv_error = 1'b0; clr_flags = 1'b0;
        chk("t5_err_set", rx_error, 1);
        chk("t5_level", rx_level, 2);
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk("t5_err_clr", rx_error, 0);
        read_chk(8'hA1);
        read_chk(8'hA2);

        // Asynchronous reset while waiting for the uart to finish, five bytes queued.
        recv(8'h77);
        sent.delete();
        for (int i = 0; i < 6; i++) write(8'hB0 + 8'(i));
        repeat (2) tick();
        chk("t6_issued_one", sent.size(), 1);
        chk("t6_level5", tx_level, 5);
        chk("t6_rx_nonempty", rx_empty, 0);
        sent.delete();
        rst = 1'b1;
        #1;
        chk("t6_async_level", tx_level, 0);
        chk("t6_async_transmit", uart_transmit, 0);
        chk("t6_async_rx_empty", rx_empty, 1);
        chk("t6_async_full", tx_full, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (60) tick();
        chk("t6_no_issue", sent.size(), 0);
        chk("t6_level0", tx_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
